missile_scheduler: RTL and testbench
====================================

Name: missile_scheduler

Overview:
- Manages a pool of NUM_SLOTS player missiles for the shooter game. Accepts fire requests from the keyboard keycode and allocates a free slot. Spawns the missile at the ship nose, advances active missiles once per frame, and retires them on collision or at the top edge.
- Sits between the keycode path, the ship position logic, the collision detector and the colour mapper. It replaces per-missile self-sequencing with one shared controller.

Parameters:
- NUM_SLOTS, 4, number of concurrent missiles (1..8).
- COOLDOWN_FRAMES, 8, frames after an accepted shot during which fire is refused.
- Y_STEP, 4, pixels a missile rises per frame.
- MISSILE_SX, 4, missile width in pixels (used for centring).
- FIRE_KEY, 8'h1A, keycode that requests fire (W).

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- keycode  in  8  current keyboard keycode.
- ShipX  in  10  ship left X.
- ShipY  in  10  ship top Y.
- Ship_sizeX  in  10  ship width.
- Collision  in  NUM_SLOTS  per-slot hit flag from the collision detector, valid for the current frame.
- MissileX  out  10*NUM_SLOTS  packed slot X positions; slot i occupies bits [10i+9:10i].
- MissileY  out  10*NUM_SLOTS  packed slot Y positions.
- MissileActive  out  NUM_SLOTS  slot-in-flight mask.
- FireAccepted  out  1  one-frame pulse when a shot is launched.
- ShotsFired  out  16  total launched shots; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (Reset=0, async):
  - All MissileActive=0, MissileX=0, MissileY=0.
  - FireAccepted=0, ShotsFired=0, cooldown counter=0.
  - Fire FSM=READY, key history register=8'h00.
- Fire edge detection:
  - fire_edge = (keycode==FIRE_KEY) && (key_prev!=FIRE_KEY).
  - key_prev registers keycode every frame.
  - Holding the key yields exactly one request.
- Fire FSM:
  - States: READY and COOLDOWN.
  - READY: if fire_edge and at least one free slot, launch, load cooldown=COOLDOWN_FRAMES-1, go to COOLDOWN. If no slot is free, the request is dropped (not queued) and the FSM stays READY.
  - COOLDOWN: decrement cooldown each frame; when cooldown==0 at the clock edge, return to READY. Any fire_edge arriving in COOLDOWN is dropped.
  - With COOLDOWN_FRAMES=8, the earliest next accepted edge is 8 frames after the previous accepted one.
- Allocation:
  - Choose the lowest-index slot whose MissileActive is 0, using the pre-update mask.
  - A slot retiring this frame is not reusable until the next frame.
- Launch into slot k:
  - MissileActive[k]<=1.
  - MissileX[k]<=ShipX+(Ship_sizeX>>1)-(MISSILE_SX>>1), 10-bit modular arithmetic.
  - MissileY[k]<=ShipY.
  - The newly launched slot does not move in its launch frame.
  - FireAccepted<=1 for one frame; ShotsFired<=ShotsFired+1.
- Per-slot flight, each frame for every active slot not being launched:
  - If Collision[i]=1, retire: Active<=0 and X/Y hold their last value.
  - Else if MissileY[i] < Y_STEP, retire at the top edge, which prevents underflow.
  - Else MissileY[i]<=MissileY[i]-Y_STEP, and X is unchanged.
- Inactive slots:
  - Collision[i] is ignored.
  - X/Y hold their value.
- Simultaneous events:
  - Collision has priority over the top-edge check.
  - Launch and retire of different slots in the same frame are both performed.
- Latency:
  - Fire edge to MissileActive = 1 frame.
  - Collision to retire = 1 frame.
- Reset asserted mid-flight clears all slots immediately, with no completion of in-progress shots.

Decomposition:
- Shared package missile_pkg holds:
  - localparam SCREEN_W=640 and SCREEN_H=480.
  - FIRE_KEY and the other keycode constants (A=8'h04, D=8'h07, W=8'h1A).
  - typedef enum fire_state_t {READY, COOLDOWN}.
  - typedef coord_t (logic [9:0]).
- One sub-module, missile_slot, one instance per slot via generate. It holds active/X/Y and has launch, collision and spawn-coordinate inputs.
- The top level holds the fire FSM, edge detect, priority allocator and shot counter.

Test Plan:
- Reset, then release; keycode=8'h1A for 1 frame with ShipX=300, ShipY=440, Ship_sizeX=32 -> next frame MissileActive=4'b0001, MissileX[0]=314, MissileY[0]=440, FireAccepted=1, ShotsFired=1; the following frame MissileY[0]=436.
- Hold keycode=8'h1A for 20 frames -> exactly one launch; FireAccepted pulses once.
- Press W at frame 0, 3 (dropped, cooldown), 8 (accepted) -> launches in slots 0 and 1 only; ShotsFired=2.
- Fill all 4 slots (presses 8 frames apart), press a 5th time -> no launch, FireAccepted=0, mask stays 4'b1111.
- Slot 1 active at Y=100, assert Collision=4'b0010 for one frame -> MissileActive[1]=0 next frame. In the same frame the lowest free slot is launched; slot 1 is not reused until the following frame.
- Slot 0 at Y=3 with Y_STEP=4 -> retires, no wrap to 1023; assert Reset low mid-flight with 3 slots active -> all outputs zero immediately, asynchronously.

Source files
------------

// File: rtl/missile_pkg.sv
// rtl/missile_pkg.sv - shared constants and types for the missile scheduler
// Contents: screen size, keycode constants, fire FSM state type, coordinate type.
package missile_pkg;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [7:0] KEY_A    = 8'h04;
   localparam logic [7:0] KEY_D    = 8'h07;
   localparam logic [7:0] KEY_W    = 8'h1A;
   localparam logic [7:0] FIRE_KEY = KEY_W;

   typedef enum logic {READY, COOLDOWN} fire_state_t;

   typedef logic [9:0] coord_t;
endpackage

// File: rtl/missile_slot.sv
// rtl/missile_slot.sv - one missile slot: in-flight flag and X/Y position
// Ports:
//   frame_clk, Reset      frame clock, async active-low reset
//   launch                load spawn coordinates and go active this frame
//   collision             hit flag for this slot (ignored while inactive)
//   spawn_x, spawn_y      spawn coordinates used on launch
//   active, pos_x, pos_y  registered slot state
module missile_slot
   import missile_pkg::*;
#(
   parameter int Y_STEP = 4
) (
   input  logic   frame_clk,
   input  logic   Reset,
   input  logic   launch,
   input  logic   collision,
   input  coord_t spawn_x,
   input  coord_t spawn_y,
   output logic   active,
   output coord_t pos_x,
   output coord_t pos_y
);
   localparam coord_t STEP = coord_t'(Y_STEP);

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         active <= 1'b0;
         pos_x  <= '0;
         pos_y  <= '0;
      end else if (launch) begin
         // a freshly launched missile sits at the spawn point for its first frame
         active <= 1'b1;
         pos_x  <= spawn_x;
         pos_y  <= spawn_y;
      end else if (active) begin
         if (collision) begin
            active <= 1'b0;
         end else if (pos_y < STEP) begin
            // retire at the top edge instead of wrapping below zero
            active <= 1'b0;
         end else begin
            pos_y <= pos_y - STEP;
         end
      end
   end
endmodule

// File: rtl/missile_scheduler.sv
// rtl/missile_scheduler.sv - shared controller for a pool of player missiles
// Ports:
//   frame_clk, Reset          frame clock, async active-low reset
//   keycode                   current keyboard keycode
//   ShipX, ShipY, Ship_sizeX  ship position and width (spawn point source)
//   Collision                 per-slot hit flags for the current frame
//   MissileX, MissileY        packed slot positions, slot i at [10i+9:10i]
//   MissileActive             slot-in-flight mask
//   FireAccepted              one-frame pulse per launched shot
//   ShotsFired                running launch count (wraps)
module missile_scheduler
   import missile_pkg::*;
#(
   parameter int         NUM_SLOTS       = 4,
   parameter int         COOLDOWN_FRAMES = 8,
   parameter int         Y_STEP          = 4,
   parameter int         MISSILE_SX      = 4,
   parameter logic [7:0] FIRE_KEY        = missile_pkg::FIRE_KEY
) (
   input  logic                    frame_clk,
   input  logic                    Reset,
   input  logic [7:0]              keycode,
   input  logic [9:0]              ShipX,
   input  logic [9:0]              ShipY,
   input  logic [9:0]              Ship_sizeX,
   input  logic [NUM_SLOTS-1:0]    Collision,
   output logic [10*NUM_SLOTS-1:0] MissileX,
   output logic [10*NUM_SLOTS-1:0] MissileY,
   output logic [NUM_SLOTS-1:0]    MissileActive,
   output logic                    FireAccepted,
   output logic [15:0]             ShotsFired
);
   localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
   localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES - 1);

   fire_state_t          state;
   logic [CW-1:0]        cooldown;
   logic [7:0]           key_prev;
   logic                 fire_edge;
   logic                 launch_go;
   logic                 found;
   logic [NUM_SLOTS-1:0] alloc_vec;
   logic [NUM_SLOTS-1:0] launch_vec;
   coord_t               spawn_x;

   assign fire_edge = (keycode == FIRE_KEY) && (key_prev != FIRE_KEY);
   assign spawn_x   = ShipX + (Ship_sizeX >> 1) - coord_t'(MISSILE_SX >> 1);

   // lowest-index free slot, taken from the mask before this frame's retires
   always_comb begin
      alloc_vec = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!MissileActive[i] && !found) begin
            alloc_vec[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   assign launch_go  = (state == READY) && fire_edge && found;
   assign launch_vec = launch_go ? alloc_vec : '0;

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state        <= READY;
         cooldown     <= '0;
         key_prev     <= 8'h00;
         FireAccepted <= 1'b0;
         ShotsFired   <= 16'h0000;
      end else begin
         key_prev     <= keycode;
         FireAccepted <= launch_go;
         case (state)
            READY: begin
               if (launch_go) begin
                  ShotsFired <= ShotsFired + 16'd1;
                  cooldown   <= CD_LOAD;
                  state      <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               // leave on the edge where the count reaches zero, so the next
               // accepted press lands COOLDOWN_FRAMES frames after the last one
               if (cooldown <= CW'(1)) state <= READY;
               if (cooldown != '0) cooldown <= cooldown - CW'(1);
            end
            default: state <= READY;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      missile_slot #(
         .Y_STEP(Y_STEP)
      ) u_slot (
         .frame_clk (frame_clk),
         .Reset     (Reset),
         .launch    (launch_vec[g]),
         .collision (Collision[g]),
         .spawn_x   (spawn_x),
         .spawn_y   (ShipY),
         .active    (MissileActive[g]),
         .pos_x     (MissileX[10*g +: 10]),
         .pos_y     (MissileY[10*g +: 10])
      );
   end
endmodule

// File: tb/tb_missile_scheduler.sv
// tb/tb_missile_scheduler.sv - self-checking bench for missile_scheduler
module tb_missile_scheduler;
   localparam int N = 4;
   localparam logic [7:0] W = 8'h1A;

   logic          frame_clk = 1'b0;
   logic          Reset;
   logic [7:0]    keycode;
   logic [9:0]    ShipX, ShipY, Ship_sizeX;
   logic [N-1:0]  Collision;
   logic [10*N-1:0] MissileX, MissileY;
   logic [N-1:0]  MissileActive;
   logic          FireAccepted;
   logic [15:0]   ShotsFired;

   typedef struct {
      int          slot;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] shots;
   } exp_t;

   exp_t q[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   pulses;

   missile_scheduler #(
      .NUM_SLOTS(N), .COOLDOWN_FRAMES(8), .Y_STEP(4), .MISSILE_SX(4), .FIRE_KEY(W)
   ) dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .keycode       (keycode),
      .ShipX         (ShipX),
      .ShipY         (ShipY),
      .Ship_sizeX    (Ship_sizeX),
      .Collision     (Collision),
      .MissileX      (MissileX),
      .MissileY      (MissileY),
      .MissileActive (MissileActive),
      .FireAccepted  (FireAccepted),
      .ShotsFired    (ShotsFired)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge frame_clk);
         @(negedge frame_clk);
      end
   endtask

   task automatic expect_launch(input int slot, input logic [9:0] x, input logic [9:0] y,
                                input logic [15:0] shots);
      exp_t e;
      e.slot = slot; e.x = x; e.y = y; e.shots = shots;
      q.push_back(e);
   endtask

   task automatic clear_all();
      Collision = '1;
      step(1);
      Collision = '0;
      check("clear_mask", 40'(MissileActive), 40'h0);
      step(8);
   endtask

   // monitor: every launch pulse is matched against the oldest expected launch
   always @(negedge frame_clk) begin
      if (Reset === 1'b1 && FireAccepted === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_fire", 40'(ShotsFired), 40'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("launch_active", 40'(MissileActive[e.slot]), 40'h1);
            check("launch_x", 40'(MissileX[10*e.slot +: 10]), 40'(e.x));
            check("launch_y", 40'(MissileY[10*e.slot +: 10]), 40'(e.y));
            check("launch_shots", 40'(ShotsFired), 40'(e.shots));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b0; keycode = 8'h00; Collision = '0;
      ShipX = 10'd300; ShipY = 10'd440; Ship_sizeX = 10'd32;
      step(2);
      check("rst_active", 40'(MissileActive), 40'h0);
      check("rst_x", MissileX, 40'h0);
      check("rst_y", MissileY, 40'h0);
      check("rst_fire", 40'(FireAccepted), 40'h0);
      check("rst_shots", 40'(ShotsFired), 40'h0);
      Reset = 1'b1;
      step(1);

      // single press: spawn at 300+16-2 = 314, then rises 4 per frame
      keycode = W;
      expect_launch(0, 10'd314, 10'd440, 16'd1);
      step(1);
      keycode = 8'h00;
      check("t1_mask", 40'(MissileActive), 40'h1);
      check("t1_fire", 40'(FireAccepted), 40'h1);
      step(1);
      check("t1_y_move", 40'(MissileY[9:0]), 40'd436);
      check("t1_fire_drop", 40'(FireAccepted), 40'h0);
      clear_all();

      // held key: one launch, then 19 moves -> 440-76 = 364
      keycode = W;
      expect_launch(0, 10'd314, 10'd440, 16'd2);
      pulses = 0;
      for (int f = 0; f < 20; f++) begin
         step(1);
         if (FireAccepted) pulses++;
      end
      keycode = 8'h00;
      check("t2_pulses", 40'(pulses), 40'd1);
      check("t2_mask", 40'(MissileActive), 40'h1);
      check("t2_y", 40'(MissileY[9:0]), 40'd364);
      clear_all();

      // presses at frames 0, 3 (cooldown, dropped), 8 (accepted)
      for (int f = 0; f <= 8; f++) begin
         keycode = (f == 0 || f == 3 || f == 8) ? W : 8'h00;
         if (f == 0) expect_launch(0, 10'd314, 10'd440, 16'd3);
         if (f == 8) expect_launch(1, 10'd314, 10'd440, 16'd4);
         step(1);
      end
      keycode = 8'h00;
      check("t3_mask", 40'(MissileActive), 40'h3);
      check("t3_shots", 40'(ShotsFired), 40'd4);
      check("t3_y0", 40'(MissileY[9:0]), 40'd408);
      clear_all();

      // fill all slots, then a fifth press is dropped
      for (int s = 0; s < 4; s++) begin
         keycode = W;
         expect_launch(s, 10'd314, 10'd440, 16'(5 + s));
         step(1);
         keycode = 8'h00;
         step(7);
      end
      keycode = W;
      step(1);
      keycode = 8'h00;
      check("t4_fire", 40'(FireAccepted), 40'h0);
      check("t4_mask", 40'(MissileActive), 40'hF);
      check("t4_shots", 40'(ShotsFired), 40'd8);
      clear_all();

      // slot 1 hit at Y=100 while a new shot fires: new shot goes to slot 2
      keycode = W;
      expect_launch(0, 10'd314, 10'd440, 16'd9);
      step(1);
      keycode = 8'h00;
      step(7);
      ShipY = 10'd128;
      keycode = W;
      expect_launch(1, 10'd314, 10'd128, 16'd10);
      step(1);
      keycode = 8'h00;
      step(7);
      check("t5_y1", 40'(MissileY[19:10]), 40'd100);
      ShipY = 10'd440;
      Collision = 4'b0010;
      keycode = W;
      expect_launch(2, 10'd314, 10'd440, 16'd11);
      step(1);
      Collision = '0;
      keycode = 8'h00;
      check("t5_mask", 40'(MissileActive), 40'h5);
      check("t5_y1_hold", 40'(MissileY[19:10]), 40'd100);
      step(7);
      keycode = W;
      expect_launch(1, 10'd314, 10'd440, 16'd12);
      step(1);
      keycode = 8'h00;
      check("t5_reuse", 40'(MissileActive), 40'h7);
      clear_all();

      // top edge: Y=3 < 4 retires with no wrap
      ShipY = 10'd3;
      keycode = W;
      expect_launch(0, 10'd314, 10'd3, 16'd13);
      step(1);
      keycode = 8'h00;
      step(1);
      check("t6_retire", 40'(MissileActive), 40'h0);
      check("t6_y_hold", 40'(MissileY[9:0]), 40'd3);
      ShipY = 10'd440;
      step(8);

      // async reset mid-flight with three slots active
      for (int s = 0; s < 3; s++) begin
         keycode = W;
         expect_launch(s, 10'd314, 10'd440, 16'(14 + s));
         step(1);
         keycode = 8'h00;
         step(7);
      end
      check("t7_mask", 40'(MissileActive), 40'h7);
      #2;
      Reset = 1'b0;
      #1;
      check("t7_rst_active", 40'(MissileActive), 40'h0);
      check("t7_rst_x", MissileX, 40'h0);
      check("t7_rst_y", MissileY, 40'h0);
      check("t7_rst_shots", 40'(ShotsFired), 40'h0);
      check("t7_rst_fire", 40'(FireAccepted), 40'h0);
      step(1);
      check("sb_drained", 40'(q.size()), 40'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
